// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU plus optional iterative multiply/divide unit.
// Define MULDIV_EN to build the multiply/divide FSM; otherwise commands 9..11 yield 0.
module exe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       EXE_CMD,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic [WIDTH-1:0] ST_value,
    input  logic [4:0]       dest,
    input  logic [WIDTH-1:0] PC,
    input  logic             MEM_R_EN,
    input  logic             MEM_W_EN,
    input  logic             WB_EN,
    input  logic             brTaken,
    output logic             stall_exe,
    output logic [WIDTH-1:0] ALU_result,
    output logic [WIDTH-1:0] ST_value_out,
    output logic [4:0]       dest_out,
    output logic [WIDTH-1:0] PC_out,
    output logic             MEM_R_EN_out,
    output logic             MEM_W_EN_out,
    output logic             WB_EN_out,
    output logic             brTaken_out
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] CMD_ADD = 4'd0;
    localparam logic [3:0] CMD_SUB = 4'd1;
    localparam logic [3:0] CMD_AND = 4'd2;
    localparam logic [3:0] CMD_OR  = 4'd3;
    localparam logic [3:0] CMD_NOR = 4'd4;
    localparam logic [3:0] CMD_XOR = 4'd5;
    localparam logic [3:0] CMD_SLL = 4'd6;
    localparam logic [3:0] CMD_SRA = 4'd7;
    localparam logic [3:0] CMD_SRL = 4'd8;

    logic [WIDTH-1:0] aluResult;
    logic [SW-1:0]    shamt;
    logic             mdDone;
    logic [WIDTH-1:0] mdResult;

    always_comb begin
        aluResult = '0;
        shamt     = val2[SW-1:0];
        case (EXE_CMD)
            CMD_ADD: aluResult = val1 + val2;
            CMD_SUB: aluResult = val1 - val2;
            CMD_AND: aluResult = val1 & val2;
            CMD_OR:  aluResult = val1 | val2;
            CMD_NOR: aluResult = ~(val1 | val2);
            CMD_XOR: aluResult = val1 ^ val2;
            CMD_SLL: aluResult = val1 << shamt;
            CMD_SRA: aluResult = $unsigned($signed(val1) >>> shamt);
            CMD_SRL: aluResult = val1 >> shamt;
            default: aluResult = '0;
        endcase
    end

`ifdef MULDIV_EN
    localparam logic [3:0] CMD_MUL  = 4'd9;
    localparam logic [3:0] CMD_DIVU = 4'd10;
    localparam logic [3:0] CMD_REMU = 4'd11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [SW-1:0]    count_q, count_d;
    logic [3:0]       op_q, op_d;
    // acc: product / partial remainder; aux: multiplier / quotient; opnd: multiplicand / divisor
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] aux_q, aux_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             isMulDiv;
    logic [WIDTH:0]   divTrial;
    logic [WIDTH:0]   divDiff;

    assign isMulDiv = (EXE_CMD == CMD_MUL) || (EXE_CMD == CMD_DIVU) || (EXE_CMD == CMD_REMU);
    assign mdResult = (op_q == CMD_DIVU) ? aux_q : acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            aux_q   <= '0;
            opnd_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            aux_q   <= aux_d;
            opnd_q  <= opnd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        acc_d     = acc_q;
        aux_d     = aux_q;
        opnd_d    = opnd_q;
        stall_exe = 1'b0;
        mdDone    = 1'b0;
        // Trial subtraction needs one extra bit: shifted remainder can exceed WIDTH bits
        divTrial  = {acc_q, aux_q[WIDTH-1]};
        divDiff   = divTrial - {1'b0, opnd_q};
        case (state_q)
            IDLE: begin
                if (isMulDiv) begin
                    stall_exe = 1'b1;
                    op_d      = EXE_CMD;
                    count_d   = SW'(WIDTH - 1);
                    state_d   = RUN;
                    if (EXE_CMD == CMD_MUL) begin
                        acc_d  = '0;
                        aux_d  = val2;
                        opnd_d = val1;
                    end else if (val2 == '0) begin
                        acc_d   = val1;
                        aux_d   = '1;
                        opnd_d  = val2;
                        state_d = DONE;
                    end else begin
                        acc_d  = '0;
                        aux_d  = val1;
                        opnd_d = val2;
                    end
                end
            end
            RUN: begin
                stall_exe = 1'b1;
                if (op_q == CMD_MUL) begin
                    if (aux_q[0]) begin
                        acc_d = acc_q + opnd_q;
                    end
                    aux_d  = aux_q >> 1;
                    opnd_d = opnd_q << 1;
                end else if (!divDiff[WIDTH]) begin
                    acc_d = divDiff[WIDTH-1:0];
                    aux_d = {aux_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = divTrial[WIDTH-1:0];
                    aux_d = {aux_q[WIDTH-2:0], 1'b0};
                end
                if (count_q == '0) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            DONE: begin
                mdDone  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
`else
    assign stall_exe = 1'b0;
    assign mdDone    = 1'b0;
    assign mdResult  = '0;
`endif

    // Stalled cycles push a bubble: control cleared, data outputs keep their last values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALU_result   <= '0;
            ST_value_out <= '0;
            dest_out     <= '0;
            PC_out       <= '0;
            MEM_R_EN_out <= 1'b0;
            MEM_W_EN_out <= 1'b0;
            WB_EN_out    <= 1'b0;
            brTaken_out  <= 1'b0;
        end else if (stall_exe) begin
            MEM_R_EN_out <= 1'b0;
            MEM_W_EN_out <= 1'b0;
            WB_EN_out    <= 1'b0;
            brTaken_out  <= 1'b0;
        end else begin
            ALU_result   <= mdDone ? mdResult : aluResult;
            ST_value_out <= ST_value;
            dest_out     <= dest;
            PC_out       <= PC;
            MEM_R_EN_out <= MEM_R_EN;
            MEM_W_EN_out <= MEM_W_EN;
            WB_EN_out    <= WB_EN;
            brTaken_out  <= brTaken;
        end
    end
endmodule

// File: tb/tb_exe_stage.sv
// Testbench for exe_stage: table-driven vectors with a scoreboard queue, plus reset sequences.
// Expectations follow the MULDIV_EN build setting.
module tb_exe_stage;
    localparam int W = 32;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expRes;
        int          expStall;
        logic [3:0]  ctrl;
        logic [4:0]  dst;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [31:0] st;
        logic [31:0] pc;
        logic [4:0]  dst;
        logic [3:0]  ctrl;
        int          stall;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  EXE_CMD;
    logic [31:0] val1, val2, ST_value, PC;
    logic [4:0]  dest;
    logic        MEM_R_EN, MEM_W_EN, WB_EN, brTaken;
    logic        stall_exe;
    logic [31:0] ALU_result, ST_value_out, PC_out;
    logic [4:0]  dest_out;
    logic        MEM_R_EN_out, MEM_W_EN_out, WB_EN_out, brTaken_out;

    int   checks;
    int   failures;
    exp_t sb[$];
    exp_t lastExp;
    vec_t vecs[0:20];

    exe_stage #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .EXE_CMD(EXE_CMD), .val1(val1), .val2(val2),
        .ST_value(ST_value), .dest(dest), .PC(PC),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN), .brTaken(brTaken),
        .stall_exe(stall_exe), .ALU_result(ALU_result), .ST_value_out(ST_value_out),
        .dest_out(dest_out), .PC_out(PC_out),
        .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out),
        .WB_EN_out(WB_EN_out), .brTaken_out(brTaken_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic [3:0] c, logic [31:0] a, logic [31:0] b, logic [31:0] r,
                                int s, logic [3:0] ctl, logic [4:0] d);
        vec_t v;
        v.cmd = c; v.a = a; v.b = b; v.expRes = r; v.expStall = s; v.ctrl = ctl; v.dst = d;
`ifndef MULDIV_EN
        if (c >= 4'd9 && c <= 4'd11) begin
            v.expRes   = '0;
            v.expStall = 0;
        end
`endif
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic driveVec(input vec_t v, input int idx);
        EXE_CMD  = v.cmd;
        val1     = v.a;
        val2     = v.b;
        dest     = v.dst;
        ST_value = 32'hC0DE_0000 ^ 32'(idx);
        PC       = 32'h0040_0000 + 32'(idx * 4);
        {MEM_R_EN, MEM_W_EN, WB_EN, brTaken} = v.ctrl;
    endtask

    task automatic pushExp(input vec_t v, input int idx);
        exp_t e;
        e.res = v.expRes; e.dst = v.dst; e.ctrl = v.ctrl; e.stall = v.expStall;
        e.st  = 32'hC0DE_0000 ^ 32'(idx);
        e.pc  = 32'h0040_0000 + 32'(idx * 4);
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string tag, input int stallSeen);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s scoreboard: got output with no pending expectation", tag);
            return;
        end
        e = sb.pop_front();
        check32({tag, " stall_cycles"}, 32'(stallSeen), 32'(e.stall));
        check32({tag, " ALU_result"}, ALU_result, e.res);
        check32({tag, " dest_out"}, {27'd0, dest_out}, {27'd0, e.dst});
        check32({tag, " ST_value_out"}, ST_value_out, e.st);
        check32({tag, " PC_out"}, PC_out, e.pc);
        check32({tag, " control_out"},
                {28'd0, MEM_R_EN_out, MEM_W_EN_out, WB_EN_out, brTaken_out}, {28'd0, e.ctrl});
        lastExp = e;
    endtask

    // Called at posedge+1; returns at posedge+1 after the result edge
    task automatic applyStimulus(input vec_t v, input int idx);
        int   stallSeen;
        logic bubbleOk;
        string tag;
        tag = $sformatf("vec%0d", idx);
        driveVec(v, idx);
        pushExp(v, idx);
        stallSeen = 0;
        bubbleOk  = 1'b1;
        #1;
        while (stall_exe === 1'b1 && stallSeen < 100) begin
            @(posedge clk);
            #1;
            stallSeen++;
            if ({MEM_R_EN_out, MEM_W_EN_out, WB_EN_out, brTaken_out} !== 4'b0 ||
                ALU_result !== lastExp.res || dest_out !== lastExp.dst ||
                ST_value_out !== lastExp.st || PC_out !== lastExp.pc) begin
                bubbleOk = 1'b0;
            end
        end
        if (stallSeen >= 100) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout: stall_exe still 1 after %0d cycles, expected release", tag, stallSeen);
        end
        if (stallSeen > 0) begin
            check32({tag, " bubble"}, {31'd0, bubbleOk}, 32'd1);
        end
        @(posedge clk);
        #1;
        checkOutput(tag, stallSeen);
    endtask

    task automatic checkAllZero(input string tag);
        check32({tag, " ALU_result"}, ALU_result, 32'd0);
        check32({tag, " ST_value_out"}, ST_value_out, 32'd0);
        check32({tag, " PC_out"}, PC_out, 32'd0);
        check32({tag, " dest_out"}, {27'd0, dest_out}, 32'd0);
        check32({tag, " control_out"},
                {28'd0, MEM_R_EN_out, MEM_W_EN_out, WB_EN_out, brTaken_out}, 32'd0);
        check32({tag, " stall_exe"}, {31'd0, stall_exe}, 32'd0);
    endtask

    initial begin
        vec_t v;
        checks   = 0;
        failures = 0;
        lastExp  = '{res: 0, st: 0, pc: 0, dst: 0, ctrl: 0, stall: 0};

        vecs[0]  = mk(4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0,  4'b0010, 5'd5);
        vecs[1]  = mk(4'd1,  32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 0,  4'b0010, 5'd6);
        vecs[2]  = mk(4'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0,  4'b1010, 5'd7);
        vecs[3]  = mk(4'd2,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 0,  4'b0100, 5'd8);
        vecs[4]  = mk(4'd3,  32'h1200_0000, 32'h0034_0056, 32'h1234_0056, 0,  4'b0001, 5'd9);
        vecs[5]  = mk(4'd4,  32'hFFFF_0000, 32'h0000_FF00, 32'h0000_00FF, 0,  4'b0010, 5'd10);
        vecs[6]  = mk(4'd5,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 0,  4'b0010, 5'd11);
        vecs[7]  = mk(4'd6,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 0,  4'b0010, 5'd12);
        vecs[8]  = mk(4'd6,  32'h0000_0003, 32'h0000_0021, 32'h0000_0006, 0,  4'b0010, 5'd13);
        vecs[9]  = mk(4'd7,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 0,  4'b0010, 5'd14);
        vecs[10] = mk(4'd8,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 0,  4'b0010, 5'd15);
        vecs[11] = mk(4'd9,  32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 33, 4'b0010, 5'd16);
        vecs[12] = mk(4'd10, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33, 4'b0010, 5'd17);
        vecs[13] = mk(4'd11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33, 4'b0010, 5'd18);
        vecs[14] = mk(4'd10, 32'h0000_0009, 32'h0000_0000, 32'hFFFF_FFFF, 1,  4'b0010, 5'd19);
        vecs[15] = mk(4'd11, 32'h0000_0009, 32'h0000_0000, 32'h0000_0009, 1,  4'b1010, 5'd20);
        vecs[16] = mk(4'd9,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 4'b0010, 5'd21);
        vecs[17] = mk(4'd10, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33, 4'b0010, 5'd22);
        vecs[18] = mk(4'd11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33, 4'b0010, 5'd23);
        vecs[19] = mk(4'd12, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 0,  4'b0010, 5'd24);
        vecs[20] = mk(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0,  4'b1111, 5'd31);

        rst = 1'b0;
        EXE_CMD = 4'd0; val1 = '0; val2 = '0; ST_value = '0; PC = '0; dest = '0;
        {MEM_R_EN, MEM_W_EN, WB_EN, brTaken} = 4'b0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset_start");
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Asynchronous reset mid-cycle with live outputs
        v = mk(4'd0, 32'h1, 32'h1, 32'h2, 0, 4'b1111, 5'd3);
        driveVec(v, 40);
        #3 rst = 1'b1;
        #1;
        checkAllZero("reset_async");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset during a multiply, then an ALU op one cycle later
        v = mk(4'd9, 32'h0000_0007, 32'h0000_0006, 32'h2A, 33, 4'b0010, 5'd9);
        driveVec(v, 41);
        repeat (10) @(posedge clk);
        #1;
`ifdef MULDIV_EN
        check32("mul_run stall_exe", {31'd0, stall_exe}, 32'd1);
        check32("mul_run WB_EN_out", {31'd0, WB_EN_out}, 32'd0);
`endif
        v = mk(4'd1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 0, 4'b0010, 5'd12);
        driveVec(v, 42);
        #2 rst = 1'b1;
        #1;
        checkAllZero("reset_in_run");
        pushExp(v, 42);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("sub_after_reset", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
